// File: rtl/bit_framer_rx.sv
// bit_framer_rx: serial bit-stream deframer.
// Hunts for SYNC_WORD in the incoming bit stream (MSB first, sampled on i_en),
// then slices the following bits into WORD_W-bit words and queues them in a
// 2-entry output FIFO drained with an o_valid/i_ready handshake.
// Optional feature macro: BIT_FRAMER_RX_PARITY_EN adds one even-parity bit
// after every data word (state PAR); bad words are dropped and o_perr pulses.
//
// Handshake: o_valid is high whenever the FIFO is non-empty, o_data is the
// head word and stays stable until it is popped; a word is consumed on every
// rising edge where o_valid && i_ready.
module bit_framer_rx #(
  parameter int                WORD_W     = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD  = 8'hA5,
  parameter int                IDLE_LIMIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_a,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_locked,
  output logic              o_ovf,
  output logic              o_perr,
  output logic [1:0]        fsm_state
);

  localparam int              CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [7:0]      IDLE_LAST = 8'(IDLE_LIMIT - 1);

`ifdef BIT_FRAMER_RX_PARITY_EN
  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  sr_q;
  logic [WORD_W-1:0]  sr_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         idle_q, idle_d;
  logic               push;
  logic [WORD_W-1:0]  push_word;

  // Output FIFO storage
  logic [WORD_W-1:0]  mem [2];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count_q;
  logic               full, pop, accept;
  logic               ovf_q;

  // Shift register content as it will be after this cycle's sample
  assign sr_next = (sr_q << 1) | WORD_W'(i_a);

`ifdef BIT_FRAMER_RX_PARITY_EN
  logic perr_d, perr_q;
  // In PAR the register still holds the finished word; the parity bit
  // itself has not been shifted in yet.
  assign push_word = sr_q;
  assign o_perr    = perr_q;
`else
  assign push_word = sr_next;
  assign o_perr    = 1'b0;
`endif

  // Shift register: take a new bit on every sample strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) sr_q <= '0;
    else if (i_en) sr_q <= sr_next;
  end

  // FSM state and counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

`ifdef BIT_FRAMER_RX_PARITY_EN
  // Parity error pulse register
  always_ff @(posedge i_clk) begin
    if (i_rst) perr_q <= 1'b0;
    else perr_q <= perr_d;
  end
`endif

  // Next-state logic: sync hunt, word slicing, idle timeout, parity check
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    push    = 1'b0;
`ifdef BIT_FRAMER_RX_PARITY_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      HUNT: begin
        cnt_d  = '0;
        idle_d = '0;
        if (i_en && (sr_next == SYNC_WORD)) state_d = DATA;
      end
      DATA: begin
        if (i_en) begin
          idle_d = '0;
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            // A completed sync word is a re-frame marker, never data
            if (sr_next != SYNC_WORD) begin
`ifdef BIT_FRAMER_RX_PARITY_EN
              state_d = PAR;
`else
              push = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = HUNT;
          cnt_d   = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
`ifdef BIT_FRAMER_RX_PARITY_EN
      PAR: begin
        if (i_en) begin
          idle_d  = '0;
          state_d = DATA;
          // Even parity: data ones plus parity bit must be even
          if (i_a == ^sr_q) push = 1'b1;
          else perr_d = 1'b1;
        end else if (idle_q == IDLE_LAST) begin
          state_d = HUNT;
          cnt_d   = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = HUNT;
        cnt_d   = '0;
        idle_d  = '0;
      end
    endcase
  end

  assign full   = (count_q == 2'd2);
  assign pop    = o_valid && i_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle
  assign accept = push && (!full || pop);

  // Two-entry output FIFO with sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !accept) ovf_q <= 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_valid   = (count_q != 2'd0);
  assign o_data    = mem[rd_ptr];
  assign o_ovf     = ovf_q;
  assign o_locked  = (state_q != HUNT);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_bit_framer_rx.sv
// tb_bit_framer_rx: bench for bit_framer_rx with a word-level reference model.
// Builds with or without BIT_FRAMER_RX_PARITY_EN; the model follows the macro.
module tb_bit_framer_rx;

  localparam int         W    = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         IDLE = 16;
`ifdef BIT_FRAMER_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         a = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] data;
  logic         valid, locked, ovf, perr;
  logic [1:0]   fsm_state;

  always #5 clk = ~clk;

  bit_framer_rx #(.WORD_W(W), .SYNC_WORD(SYNC), .IDLE_LIMIT(IDLE)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_a      (a),
    .o_data   (data),
    .o_valid  (valid),
    .i_ready  (ready),
    .o_locked (locked),
    .o_ovf    (ovf),
    .o_perr   (perr),
    .fsm_state(fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Word-level view: a bit history, a locked flag, a count of bits collected
  // since lock, an idle run length and a queue of delivered words.
  logic [W-1:0] m_sr;
  logic [W-1:0] m_hold_word;
  bit           m_locked, m_par_wait, m_ovf, m_perr, m_stall;
  int           m_bits, m_idle;
  logic [W-1:0] exp_q[$];

  task automatic model_step(input bit r, input bit e, input bit d, input bit rd);
    bit           do_pop, do_push;
    logic [W-1:0] w;
    if (r) begin
      m_sr = '0; m_locked = 0; m_par_wait = 0; m_ovf = 0; m_perr = 0;
      m_stall = 0; m_bits = 0; m_idle = 0; exp_q.delete();
      return;
    end
    do_pop  = (exp_q.size() != 0) && rd;
    m_stall = (exp_q.size() != 0) && !rd;
    do_push = 0;
    w       = '0;
    m_perr  = 0;
    if (e) m_sr = {m_sr[W-2:0], d};
    if (!m_locked) begin
      if (e && m_sr == SYNC) begin
        m_locked = 1; m_bits = 0; m_idle = 0;
      end
    end else if (e) begin
      m_idle = 0;
      if (m_par_wait) begin
        m_par_wait = 0;
        if (d == ^m_hold_word) begin do_push = 1; w = m_hold_word; end
        else m_perr = 1;
      end else begin
        m_bits++;
        if (m_bits == W) begin
          m_bits = 0;
          if (m_sr != SYNC) begin
            if (PAR_EN) begin m_par_wait = 1; m_hold_word = m_sr; end
            else begin do_push = 1; w = m_sr; end
          end
        end
      end
    end else begin
      m_idle++;
      if (m_idle == IDLE) begin
        m_locked = 0; m_bits = 0; m_par_wait = 0; m_idle = 0;
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      if (exp_q.size() < 2) exp_q.push_back(w);
      else m_ovf = 1;
    end
  endtask

  // ---------------- compare process ----------------
  bit           chk_on = 0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid", valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("data", data, exp_q[0]);
      check("locked", locked, m_locked);
      check("ovf", ovf, m_ovf);
      check("perr", perr, m_perr);
      if (m_stall && valid) check("data_stable", data, prev_data);
      prev_data = data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit r, input bit e, input bit d, input bit rd);
    rst = r; en = e; a = d; ready = rd;
    @(posedge clk);
    model_step(r, e, d, rd);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic send_byte(input logic [W-1:0] b, input bit rd);
    for (int i = W - 1; i >= 0; i--) cyc(0, 1, b[i], rd);
  endtask

  // Data word plus parity bit when enabled; the final bit uses rd_last
  task automatic send_word_rl(input logic [W-1:0] b, input bit rd, input bit rd_last);
    for (int i = W - 1; i >= 0; i--)
      cyc(0, 1, b[i], (i == 0 && !PAR_EN) ? rd_last : rd);
    if (PAR_EN) cyc(0, 1, ^b, rd_last);
  endtask

  task automatic send_word(input logic [W-1:0] b, input bit rd);
    send_word_rl(b, rd, rd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    chk_on = 1;
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_locked", locked, 0);
    check("rst_ovf", ovf, 0);
    check("rst_perr", perr, 0);
    check("rst_state", fsm_state, 0);

    // Lock on A5, then one data word 3C
    send_byte(8'hA5, 1);
    check("lock_after_sync", locked, 1);
    check("no_word_on_sync", valid, 0);
    send_word(8'h3C, 1);
    check("word_3c_valid", valid, 1);
    check("word_3c_data", data, 8'h3C);
    cyc(0, 0, 0, 1);
    check("word_3c_one_cycle", valid, 0);

    // Sync word inside DATA is a re-frame marker
    send_byte(8'hA5, 1);
    check("reframe_no_valid", valid, 0);
    check("reframe_locked", locked, 1);
    send_word(8'h5A, 1);
    check("after_reframe_valid", valid, 1);
    check("after_reframe_data", data, 8'h5A);
    cyc(0, 0, 0, 1);

    // Overflow: three words with consumer stalled
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    send_word(8'h33, 0);
    check("ovf_head", data, 8'h11);
    check("ovf_flag", ovf, 1);
    cyc(0, 0, 0, 1);
    check("drain_second", data, 8'h22);
    cyc(0, 0, 0, 1);
    check("drain_empty", valid, 0);
    check("ovf_sticky", ovf, 1);

    // Push and pop in the same cycle on a full FIFO
    do_reset();
    send_byte(8'hA5, 0);
    send_word(8'h44, 0);
    send_word(8'h55, 0);
    send_word_rl(8'h66, 0, 1);
    check("full_pushpop_no_ovf", ovf, 0);
    check("full_pushpop_head", data, 8'h55);
    cyc(0, 0, 0, 1);
    check("full_pushpop_tail", data, 8'h66);
    cyc(0, 0, 0, 1);

    // Idle timeout drops lock, later data without sync is ignored
    do_reset();
    send_byte(8'hA5, 1);
    for (int i = 0; i < IDLE - 1; i++) cyc(0, 0, 0, 1);
    check("idle_still_locked", locked, 1);
    cyc(0, 0, 0, 1);
    check("idle_unlocked", locked, 0);
    send_byte(8'h3C, 1);
    cyc(0, 0, 0, 1);
    check("nosync_no_word", valid, 0);
    check("nosync_unlocked", locked, 0);

    // Reset in the middle of a word
    do_reset();
    send_byte(8'hA5, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i[0], 0);
    cyc(1, 0, 0, 0);
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    check("midrst_locked", locked, 0);
    check("midrst_state", fsm_state, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, i[0], 1);
    cyc(0, 0, 0, 1);
    check("midrst_no_word", valid, 0);

    // Words with sampling gaps and a randomly stalling consumer
    do_reset();
    send_byte(8'hA5, 1);
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] b;
      b = W'(8'h17 * (k + 3));
      if (b == SYNC) b = 8'h0F;
      for (int i = W - 1; i >= 0; i--) begin
        cyc(0, 1, b[i], 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
      end
      if (PAR_EN) cyc(0, 1, ^b, 1'($urandom_range(0, 1)));
    end
    repeat (4) cyc(0, 0, 0, 1);
    check("gap_drained", valid, 0);

`ifdef BIT_FRAMER_RX_PARITY_EN
    // Parity: good word accepted, bad word dropped with a pulse
    do_reset();
    send_byte(8'hA5, 1);
    send_byte(8'h07, 1);
    cyc(0, 1, 1, 1);
    check("par_good_valid", valid, 1);
    check("par_good_data", data, 8'h07);
    cyc(0, 0, 0, 1);
    send_byte(8'h07, 1);
    cyc(0, 1, 0, 1);
    check("par_bad_perr", perr, 1);
    check("par_bad_no_valid", valid, 0);
    check("par_bad_locked", locked, 1);
    cyc(0, 0, 0, 1);
    check("par_perr_pulse", perr, 0);
`endif

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
